// File: rtl/morra_pkg.sv
// Shared definitions for the morra game FSM and its scoreboard stage.
package morra_pkg;

    typedef enum logic [1:0] {
        NESSUNO = 2'b00,
        G1      = 2'b01,
        G2      = 2'b10,
        PARI    = 2'b11
    } esito_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GIOCO = 2'b01,
        FINE  = 2'b10
    } tab_stato_t;

    function automatic logic is_vittoria(input logic [1:0] e);
        return (e == G1) || (e == G2);
    endfunction

endpackage

// File: rtl/morra_contatore_sat.sv
// Saturating W-bit counter; clr together with inc restarts the count at 1.
module morra_contatore_sat #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // count register: clear/restart has priority, increment stops at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= {W{1'b0}};
        end else if (clr) begin
            cnt <= inc ? W'(1) : {W{1'b0}};
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/morra_tabellone.sv
// Scoreboard for the morra game: round statistics, history, longest streak
// and a valid/ack handshake for the final match result.
module morra_tabellone
    import morra_pkg::*;
#(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               INIZIO,
    input  logic [1:0]         MANCHE,
    input  logic [1:0]         PARTITA,
    input  logic               RIS_ACK,
    output logic [W-1:0]       VITTORIE1,
    output logic [W-1:0]       VITTORIE2,
    output logic [W-1:0]       PAREGGI,
    output logic [W-1:0]       INVALIDE,
    output logic [W-1:0]       SERIE_MAX,
    output logic [2*DEPTH-1:0] STORIA,
    output logic [1:0]         RISULTATO,
    output logic               RIS_VALID,
    output logic               ERRORE
);

    tab_stato_t   stato_r, stato_nxt_s;
    esito_t       ultimo_r;
    logic [W-1:0] serie_r;
    logic [W-1:0] serie_nxt_s;
    logic         conta_s, chiudi_s, err_set_s, ack_ok_s;
    logic         win_s, pari_s, inv_s, serie_clr_s;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stato_r <= IDLE;
        end else begin
            stato_r <= stato_nxt_s;
        end
    end

    // next state and per-cycle strobes; INIZIO overrides everything
    always_comb begin
        stato_nxt_s = stato_r;
        conta_s     = 1'b0;
        chiudi_s    = 1'b0;
        err_set_s   = 1'b0;
        ack_ok_s    = 1'b0;
        if (INIZIO) begin
            stato_nxt_s = GIOCO;
        end else begin
            case (stato_r)
                IDLE: begin
                    stato_nxt_s = IDLE;
                end
                GIOCO: begin
                    conta_s = 1'b1;
                    if (PARTITA != NESSUNO) begin
                        chiudi_s    = 1'b1;
                        stato_nxt_s = FINE;
                        err_set_s   = (PARTITA != MANCHE);
                    end else begin
                        stato_nxt_s = GIOCO;
                    end
                end
                FINE: begin
                    err_set_s = (PARTITA != NESSUNO);
                    if (RIS_ACK) begin
                        ack_ok_s    = 1'b1;
                        stato_nxt_s = IDLE;
                    end else begin
                        stato_nxt_s = FINE;
                    end
                end
                default: begin
                    stato_nxt_s = IDLE;
                end
            endcase
        end
    end

    assign win_s  = conta_s && is_vittoria(MANCHE);
    assign pari_s = conta_s && (MANCHE == PARI);
    assign inv_s  = conta_s && (MANCHE == NESSUNO);
    // a win by the other player (or a draw) restarts the run
    assign serie_clr_s = INIZIO || pari_s || (win_s && (MANCHE != ultimo_r));

    // streak value as it will be after this cycle, used for SERIE_MAX
    always_comb begin
        serie_nxt_s = serie_r;
        if (win_s) begin
            if (MANCHE != ultimo_r) begin
                serie_nxt_s = W'(1);
            end else if (serie_r != {W{1'b1}}) begin
                serie_nxt_s = serie_r + W'(1);
            end else begin
                serie_nxt_s = serie_r;
            end
        end else if (pari_s) begin
            serie_nxt_s = {W{1'b0}};
        end else begin
            serie_nxt_s = serie_r;
        end
    end

    morra_contatore_sat #(.W(W)) u_vitt1 (
        .clk(clk), .rst_n(rst_n), .clr(INIZIO),
        .inc(win_s && (MANCHE == G1)), .cnt(VITTORIE1)
    );
    morra_contatore_sat #(.W(W)) u_vitt2 (
        .clk(clk), .rst_n(rst_n), .clr(INIZIO),
        .inc(win_s && (MANCHE == G2)), .cnt(VITTORIE2)
    );
    morra_contatore_sat #(.W(W)) u_pari (
        .clk(clk), .rst_n(rst_n), .clr(INIZIO),
        .inc(pari_s), .cnt(PAREGGI)
    );
    morra_contatore_sat #(.W(W)) u_inv (
        .clk(clk), .rst_n(rst_n), .clr(INIZIO),
        .inc(inv_s), .cnt(INVALIDE)
    );
    morra_contatore_sat #(.W(W)) u_serie (
        .clk(clk), .rst_n(rst_n), .clr(serie_clr_s),
        .inc(win_s), .cnt(serie_r)
    );

    // last winner, longest run and round history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ultimo_r  <= NESSUNO;
            SERIE_MAX <= {W{1'b0}};
            STORIA    <= {(2*DEPTH){1'b0}};
        end else if (INIZIO) begin
            ultimo_r  <= NESSUNO;
            SERIE_MAX <= {W{1'b0}};
            STORIA    <= {(2*DEPTH){1'b0}};
        end else begin
            if (win_s) begin
                ultimo_r <= esito_t'(MANCHE);
            end else if (pari_s) begin
                ultimo_r <= NESSUNO;
            end else begin
                ultimo_r <= ultimo_r;
            end
            if (conta_s && (serie_nxt_s > SERIE_MAX)) begin
                SERIE_MAX <= serie_nxt_s;
            end else begin
                SERIE_MAX <= SERIE_MAX;
            end
            if (conta_s && (MANCHE != NESSUNO)) begin
                STORIA <= {STORIA[2*DEPTH-3:0], MANCHE};
            end else begin
                STORIA <= STORIA;
            end
        end
    end

    // result latch, handshake and sticky consistency error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RISULTATO <= 2'b00;
            RIS_VALID <= 1'b0;
            ERRORE    <= 1'b0;
        end else if (INIZIO) begin
            RISULTATO <= 2'b00;
            RIS_VALID <= 1'b0;
            ERRORE    <= 1'b0;
        end else begin
            if (chiudi_s) begin
                RISULTATO <= PARTITA;
                RIS_VALID <= 1'b1;
            end else if (ack_ok_s) begin
                RISULTATO <= RISULTATO;
                RIS_VALID <= 1'b0;
            end else begin
                RISULTATO <= RISULTATO;
                RIS_VALID <= RIS_VALID;
            end
            ERRORE <= ERRORE | err_set_s;
        end
    end

endmodule

// File: tb/tb_morra_tabellone.sv
// Directed scoreboard bench for morra_tabellone; a W=5 and a W=2 instance share stimulus.
module tb_morra_tabellone;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inizio;
    logic [1:0] manche;
    logic [1:0] partita;
    logic       ris_ack;

    logic [4:0] a_v1, a_v2, a_par, a_inv, a_smax;
    logic [7:0] a_storia;
    logic [1:0] a_ris;
    logic       a_rv, a_err;
    logic [1:0] b_v1, b_v2, b_par, b_inv, b_smax;
    logic [7:0] b_storia;
    logic [1:0] b_ris;
    logic       b_rv, b_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         v1, v2, par, inv, smax;
        logic [7:0] storia;
        logic [1:0] ris;
        logic       rv, err;
    } exp_t;
    exp_t sb[$];

    int         m_v1, m_v2, m_par, m_inv, m_smax, m_streak, m_st;
    logic [1:0] m_last, m_ris;
    logic [7:0] m_storia;
    logic       m_rv, m_err;

    always #5 clk = ~clk;

    morra_tabellone #(.W(5), .DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .INIZIO(inizio), .MANCHE(manche),
        .PARTITA(partita), .RIS_ACK(ris_ack),
        .VITTORIE1(a_v1), .VITTORIE2(a_v2), .PAREGGI(a_par), .INVALIDE(a_inv),
        .SERIE_MAX(a_smax), .STORIA(a_storia), .RISULTATO(a_ris),
        .RIS_VALID(a_rv), .ERRORE(a_err)
    );

    morra_tabellone #(.W(2), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .INIZIO(inizio), .MANCHE(manche),
        .PARTITA(partita), .RIS_ACK(ris_ack),
        .VITTORIE1(b_v1), .VITTORIE2(b_v2), .PAREGGI(b_par), .INVALIDE(b_inv),
        .SERIE_MAX(b_smax), .STORIA(b_storia), .RISULTATO(b_ris),
        .RIS_VALID(b_rv), .ERRORE(b_err)
    );

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_v1 = 0; m_v2 = 0; m_par = 0; m_inv = 0; m_smax = 0; m_streak = 0;
        m_st = 0; m_last = 2'b00; m_ris = 2'b00; m_storia = 8'h00;
        m_rv = 1'b0; m_err = 1'b0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.v1 = m_v1; e.v2 = m_v2; e.par = m_par; e.inv = m_inv; e.smax = m_smax;
        e.storia = m_storia; e.ris = m_ris; e.rv = m_rv; e.err = m_err;
        sb.push_back(e);
    endtask

    // reference behaviour of one clock edge with the current inputs
    task automatic model_step();
        if (inizio) begin
            model_reset();
            m_st = 1;
        end else if (m_st == 1) begin
            case (manche)
                2'b01, 2'b10: begin
                    if (manche == 2'b01) m_v1++; else m_v2++;
                    if (m_last == manche) m_streak++;
                    else begin m_streak = 1; m_last = manche; end
                end
                2'b11: begin m_par++; m_streak = 0; m_last = 2'b00; end
                default: m_inv++;
            endcase
            if (manche != 2'b00) m_storia = {m_storia[5:0], manche};
            if (m_streak > m_smax) m_smax = m_streak;
            if (partita != 2'b00) begin
                if (partita != manche) m_err = 1'b1;
                m_ris = partita; m_rv = 1'b1; m_st = 2;
            end
        end else if (m_st == 2) begin
            if (partita != 2'b00) m_err = 1'b1;
            if (ris_ack) begin m_rv = 1'b0; m_st = 0; end
        end
    endtask

    task automatic cmp_all();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("w5_vittorie1", a_v1, sat(e.v1, 31));
        chk("w5_vittorie2", a_v2, sat(e.v2, 31));
        chk("w5_pareggi", a_par, sat(e.par, 31));
        chk("w5_invalide", a_inv, sat(e.inv, 31));
        chk("w5_serie_max", a_smax, sat(e.smax, 31));
        chk("w5_storia", a_storia, e.storia);
        chk("w5_risultato", a_ris, e.ris);
        chk("w5_ris_valid", a_rv, e.rv);
        chk("w5_errore", a_err, e.err);
        chk("w2_vittorie1", b_v1, sat(e.v1, 3));
        chk("w2_vittorie2", b_v2, sat(e.v2, 3));
        chk("w2_pareggi", b_par, sat(e.par, 3));
        chk("w2_invalide", b_inv, sat(e.inv, 3));
        chk("w2_serie_max", b_smax, sat(e.smax, 3));
        chk("w2_storia", b_storia, e.storia);
        chk("w2_ris_valid", b_rv, e.rv);
        chk("w2_errore", b_err, e.err);
    endtask

    task automatic cyc(input logic i, input logic [1:0] m, input logic [1:0] p, input logic a);
        @(negedge clk);
        inizio = i; manche = m; partita = p; ris_ack = a;
        model_step();
        push_exp();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    initial begin
        rst_n = 1'b0; inizio = 1'b0; manche = 2'b00; partita = 2'b00; ris_ack = 1'b0;
        model_reset();
        #3;
        push_exp();
        cmp_all();
        @(negedge clk);
        rst_n = 1'b1;

        // start, inputs in the INIZIO cycle ignored
        cyc(1'b1, 2'b11, 2'b01, 1'b0);
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        cyc(1'b0, 2'b01, 2'b00, 1'b1);
        cyc(1'b0, 2'b10, 2'b00, 1'b0);
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        chk("t1_v1", a_v1, 32'd3);
        chk("t1_v2", a_v2, 32'd1);
        chk("t1_smax", a_smax, 32'd2);
        chk("t1_storia", a_storia, 32'h59);
        chk("t1_rv", a_rv, 32'd0);

        // invalid round does not break the run
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 2'b00, 1'b0);
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        chk("t2_inv", a_inv, 32'd1);
        chk("t2_smax", a_smax, 32'd3);
        cyc(1'b0, 2'b11, 2'b00, 1'b0);
        chk("t2_par", a_par, 32'd1);
        chk("t2_storia", a_storia, 32'h57);

        // final round and handshake
        cyc(1'b0, 2'b10, 2'b10, 1'b0);
        chk("t3_ris", a_ris, 32'd2);
        chk("t3_rv", a_rv, 32'd1);
        for (int k = 0; k < 5; k++) cyc(1'b0, 2'b01, 2'b00, 1'b0);
        chk("t3_rv_hold", a_rv, 32'd1);
        chk("t3_v1_frozen", a_v1, 32'd5);
        cyc(1'b0, 2'b00, 2'b00, 1'b1);
        chk("t3_rv_ack", a_rv, 32'd0);
        cyc(1'b0, 2'b01, 2'b00, 1'b1);
        chk("t3_idle_v1", a_v1, 32'd5);
        chk("t3_idle_v2", a_v2, 32'd2);

        // saturation of the narrow instance
        cyc(1'b1, 2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 6; k++) cyc(1'b0, 2'b01, 2'b00, 1'b0);
        chk("t4_w2_v1", b_v1, 32'd3);
        chk("t4_w2_smax", b_smax, 32'd3);
        chk("t4_w5_v1", a_v1, 32'd6);

        // inconsistent final result
        cyc(1'b0, 2'b10, 2'b01, 1'b0);
        chk("t5_err", a_err, 32'd1);
        chk("t5_ris", a_ris, 32'd1);
        cyc(1'b0, 2'b00, 2'b11, 1'b0);
        cyc(1'b1, 2'b00, 2'b00, 1'b0);
        chk("t5_err_clr", a_err, 32'd0);
        chk("t5_v1_clr", a_v1, 32'd0);

        // INIZIO together with RIS_ACK in FINE
        cyc(1'b0, 2'b01, 2'b01, 1'b0);
        chk("t6_rv", a_rv, 32'd1);
        cyc(1'b1, 2'b00, 2'b00, 1'b1);
        chk("t6_rv_drop", a_rv, 32'd0);
        cyc(1'b0, 2'b10, 2'b00, 1'b0);
        chk("t6_gioco_v2", a_v2, 32'd1);

        // asynchronous reset mid-match
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        push_exp();
        cmp_all();
        chk("t7_v1_async", a_v1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        chk("t7_idle_v1", a_v1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
